// File: rtl/clock_pkg.sv
// clock_pkg: shared limits, mode/alarm enums, strobe bundle and month-length helper
package clock_pkg;
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HRS_MAX = 5'd23;
  localparam logic [3:0] MONTH_MAX = 4'd12;
  typedef enum logic [1:0] {RUN, TSET, ASET} mode_e;
  typedef enum logic {IDLE, RING} buzz_st_e;
  typedef struct packed {
    logic sec, min, hrs, day, date, month, ld, amin, ahrs;
    logic [4:0] ld_val;
  } strb_t;
  function automatic logic [4:0] dim(input logic [3:0] month, input logic [4:0] days_feb);
    dim = (month == 4'd0 || month > MONTH_MAX) ? 5'd31 :
          (month == 4'd2) ? days_feb :
          (month == 4'd4 || month == 4'd6 || month == 4'd9 || month == 4'd11) ? 5'd30 : 5'd31;
  endfunction
endpackage

// File: rtl/buzz_ctrl.sv
// buzz_ctrl: alarm match (time+1min == alarm at :59) and IDLE/RING FSM; in Clk,Reset,fire,Alarmon,Sec,Min,Hrs,AMin,AHrs; out Buzz
module buzz_ctrl
  import clock_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       fire,
  input  logic       Alarmon,
  input  logic [5:0] Sec,
  input  logic [5:0] Min,
  input  logic [4:0] Hrs,
  input  logic [5:0] AMin,
  input  logic [4:0] AHrs,
  output logic       Buzz
);
  buzz_st_e st_d, st_q;
  logic [5:0] nmin;
  logic [4:0] nhrs;
  logic hit;
  always_comb begin
    nmin = (Min == MIN_MAX) ? 6'd0 : Min + 6'd1;
    nhrs = (Min != MIN_MAX) ? Hrs : (Hrs == HRS_MAX) ? 5'd0 : Hrs + 5'd1;
    hit = fire && Alarmon && Sec == SEC_MAX && nmin == AMin && nhrs == AHrs;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) st_q <= IDLE;
    else st_q <= st_d;
  always_comb st_d = (st_q == RING) ? (Alarmon ? RING : IDLE) : (hit ? RING : IDLE);
  always_comb Buzz = st_q == RING;
endmodule

// File: rtl/time_adv_sched.sv
// time_adv_sched: per-Pulse carry/set-mode strobe scheduler with date clamp; in Clk,Reset,Pulse,modes,buttons,time/alarm values; out registered strobes, DateLd/DateLdVal, Buzz
module time_adv_sched
  import clock_pkg::*;
#(
  parameter int DAYS_FEB = 28
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Pulse,
  input  logic       Timeset,
  input  logic       Alarmset,
  input  logic       Minadv,
  input  logic       Hrsadv,
  input  logic       Dayadv,
  input  logic       Dateadv,
  input  logic       Monthadv,
  input  logic       Alarmon,
  input  logic [5:0] Sec,
  input  logic [5:0] Min,
  input  logic [4:0] Hrs,
  input  logic [4:0] Date,
  input  logic [3:0] Month,
  input  logic [5:0] AMin,
  input  logic [4:0] AHrs,
  output logic       SecInc,
  output logic       MinInc,
  output logic       HrsInc,
  output logic       DayInc,
  output logic       DateInc,
  output logic       MonthInc,
  output logic       DateLd,
  output logic [4:0] DateLdVal,
  output logic       AMinInc,
  output logic       AHrsInc,
  output logic       Buzz
);
  mode_e mode;
  strb_t out_d, out_q;
  logic clamp_pend_d, clamp_pend_q, clamp_now_d, clamp_now_q;
  logic run, c_sec, c_min, c_hrs, at_end, date_hit, clamp_ld;
  logic [4:0] dm;
  always_comb begin
    mode = Timeset ? TSET : Alarmset ? ASET : RUN;
    run = mode != TSET;
    dm = dim(Month, 5'(DAYS_FEB));
    c_sec = Sec == SEC_MAX;
    c_min = c_sec && Min == MIN_MAX;
    c_hrs = c_min && Hrs == HRS_MAX;
    at_end = Date == dm;
    // the clamp owns the date counter on its cycle, so any Pulse date step is dropped
    date_hit = Pulse && !clamp_now_q && (run ? c_hrs : Dateadv);
    clamp_ld = clamp_now_q && Date > dm;
    out_d.sec = Pulse && run;
    out_d.min = Pulse && (run ? c_sec : Minadv);
    out_d.hrs = Pulse && (run ? c_min : Hrsadv);
    out_d.day = Pulse && (run ? c_hrs : Dayadv);
    out_d.date = date_hit && !at_end;
    out_d.ld = clamp_ld || (date_hit && at_end);
    out_d.month = run ? date_hit && at_end : Pulse && Monthadv;
    out_d.amin = Pulse && mode == ASET && Minadv;
    out_d.ahrs = Pulse && mode == ASET && Hrsadv;
    out_d.ld_val = clamp_ld ? dm : {4'd0, out_d.ld};
    // two-stage delay: Month counter updates one Clk after MonthInc, checked the Clk after
    clamp_pend_d = Pulse && mode == TSET && Monthadv;
    clamp_now_d = clamp_pend_q;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      out_q <= '0;
      clamp_pend_q <= 1'b0;
      clamp_now_q <= 1'b0;
    end else begin
      out_q <= out_d;
      clamp_pend_q <= clamp_pend_d;
      clamp_now_q <= clamp_now_d;
    end
  assign SecInc = out_q.sec;
  assign MinInc = out_q.min;
  assign HrsInc = out_q.hrs;
  assign DayInc = out_q.day;
  assign DateInc = out_q.date;
  assign MonthInc = out_q.month;
  assign DateLd = out_q.ld;
  assign DateLdVal = out_q.ld_val;
  assign AMinInc = out_q.amin;
  assign AHrsInc = out_q.ahrs;
  buzz_ctrl u_buzz (
    .Clk(Clk), .Reset(Reset), .fire(Pulse && mode == RUN), .Alarmon(Alarmon),
    .Sec(Sec), .Min(Min), .Hrs(Hrs), .AMin(AMin), .AHrs(AHrs), .Buzz(Buzz)
  );
endmodule

// File: tb/tb_time_adv_sched.sv
// tb_time_adv_sched: randomized and directed checks against a calendar-arithmetic model
module tb_time_adv_sched;
  logic Clk = 0, Reset = 1, Pulse = 0;
  logic Timeset = 0, Alarmset = 0, Minadv = 0, Hrsadv = 0, Dayadv = 0, Dateadv = 0, Monthadv = 0, Alarmon = 0;
  logic [5:0] Sec, Min, AMin;
  logic [4:0] Hrs, Date, AHrs, DateLdVal;
  logic [3:0] Month;
  logic SecInc, MinInc, HrsInc, DayInc, DateInc, MonthInc, DateLd, AMinInc, AHrsInc, Buzz;
  int s = 0, m = 0, h = 0, d = 1, mo = 1, am = 0, ah = 0;
  bit ts, as, ma, ha, dya, dta, moa, aon, ring;
  int n_vec = 0, n_err = 0;
  int ml [1:12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
  assign Sec = 6'(s);
  assign Min = 6'(m);
  assign Hrs = 5'(h);
  assign Date = 5'(d);
  assign Month = 4'(mo);
  assign AMin = 6'(am);
  assign AHrs = 5'(ah);
  always #5 Clk = ~Clk;
  time_adv_sched #(.DAYS_FEB(28)) dut (
    .Clk(Clk), .Reset(Reset), .Pulse(Pulse), .Timeset(Timeset), .Alarmset(Alarmset),
    .Minadv(Minadv), .Hrsadv(Hrsadv), .Dayadv(Dayadv), .Dateadv(Dateadv), .Monthadv(Monthadv),
    .Alarmon(Alarmon), .Sec(Sec), .Min(Min), .Hrs(Hrs), .Date(Date), .Month(Month),
    .AMin(AMin), .AHrs(AHrs), .SecInc(SecInc), .MinInc(MinInc), .HrsInc(HrsInc), .DayInc(DayInc),
    .DateInc(DateInc), .MonthInc(MonthInc), .DateLd(DateLd), .DateLdVal(DateLdVal),
    .AMinInc(AMinInc), .AHrsInc(AHrsInc), .Buzz(Buzz)
  );
  function automatic int dim_tb(int x);
    return (x >= 1 && x <= 12) ? ml[x] : 31;
  endfunction
  function automatic logic [31:0] obs();
    return 32'({SecInc, MinInc, HrsInc, DayInc, DateInc, MonthInc, DateLd, AMinInc, AHrsInc});
  endfunction
  function automatic bit coin();
    return 1'($urandom);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t %0d/%0d %0d:%0d:%0d)", tag, got, exp, $time, mo, d, h, m, s);
    end
  endtask
  task automatic setup(input int nmo, input int nd, input int nh, input int nm, input int ns);
    mo = nmo; d = nd; h = nh; m = nm; s = ns;
  endtask
  task automatic scramble();
    {Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Dateadv, Monthadv} = 7'($urandom);
  endtask
  task automatic step();
    logic [8:0] e;
    int ns, nm, nh, nd, nmo, nam, nah, cv;
    bit trig, cl;
    ns = s; nm = m; nh = h; nd = d; nmo = mo; nam = am; nah = ah;
    @(negedge Clk);
    {Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Dateadv, Monthadv} = {ts, as, ma, ha, dya, dta, moa};
    Alarmon = aon;
    Pulse = 1;
    e = '0;
    if (ts) begin
      e[7] = ma; e[6] = ha; e[5] = dya; e[3] = moa;
      e[4] = dta && d != dim_tb(mo);
      e[2] = dta && d == dim_tb(mo);
      if (ma) nm = (m + 1) % 60;
      if (ha) nh = (h + 1) % 24;
      if (dta) nd = e[2] ? 1 : d + 1;
      if (moa) nmo = mo % 12 + 1;
    end else begin
      ns = (s + 1) % 60;
      e[8] = 1;
      if (ns == 0) begin nm = (m + 1) % 60; e[7] = 1; end
      if (e[7] && nm == 0) begin nh = (h + 1) % 24; e[6] = 1; end
      if (e[6] && nh == 0) begin
        e[5] = 1;
        nd = (d == dim_tb(mo)) ? 1 : d + 1;
        e[4] = nd != 1;
        e[2] = nd == 1;
      end
      if (e[2]) begin nmo = mo % 12 + 1; e[3] = 1; end
      if (as) begin
        e[1] = ma; e[0] = ha;
        if (ma) nam = (am + 1) % 60;
        if (ha) nah = (ah + 1) % 24;
      end
    end
    trig = !ts && !as && aon && s == 59 && ((h * 60 + m + 1) % 1440) == ah * 60 + am;
    ring = aon && (ring || trig);
    @(negedge Clk);
    Pulse = 0;
    chk("strobe", obs(), 32'(e));
    if (e[2]) chk("ldval", 32'(DateLdVal), 1);
    chk("buzz", 32'(Buzz), 32'(ring));
    s = ns; m = nm; h = nh; d = nd; mo = nmo; am = nam; ah = nah;
    cl = ts && moa && d > dim_tb(mo);
    cv = dim_tb(mo);
    scramble();
    @(negedge Clk);
    chk("hold", obs(), 0);
    scramble();
    @(negedge Clk);
    chk("clamp", obs(), cl ? 4 : 0);
    if (cl) begin
      chk("clampval", 32'(DateLdVal), 32'(cv));
      d = cv;
    end
  endtask
  initial begin
    repeat (2) @(negedge Clk);
    chk("rst_strobe", obs(), 0);
    chk("rst_val", 32'(DateLdVal), 0);
    chk("rst_buzz", 32'(Buzz), 0);
    Reset = 0;
    {ts, as, ma, ha, dya, dta, moa, aon} = '0;
    setup(12, 31, 23, 59, 59); step();
    setup(2, 28, 23, 59, 59); step();
    setup(4, 30, 23, 59, 59); step();
    setup(1, 30, 23, 59, 59); step();
    setup(1, 1, 10, 20, 30);
    {ts, as, ma, ha, dya, dta, moa} = 7'b1000011;
    repeat (11) step();
    setup(1, 31, 5, 5, 5);
    {ts, as, ma, ha, dya, dta, moa} = 7'b1000001;
    step();
    {ts, as, ma, ha, dya, dta, moa} = 7'b0101000;
    setup(3, 3, 23, 59, 58);
    repeat (3) step();
    {ts, as, ma, ha, dya, dta, moa} = 7'b1101000;
    step();
    {ts, as, ma, ha, dya, dta, moa} = '0;
    aon = 1; am = 30; ah = 6;
    setup(5, 5, 6, 29, 59);
    step();
    step();
    @(negedge Clk);
    Alarmon = 0;
    @(negedge Clk);
    chk("buzz_off", 32'(Buzz), 0);
    aon = 0; ring = 0;
    aon = 1;
    setup(5, 5, 6, 29, 59);
    step();
    @(negedge Clk);
    Reset = 1;
    #1 chk("rst_ring", 32'(Buzz), 0);
    ring = 0;
    @(negedge Clk);
    Reset = 0;
    aon = 0; Alarmon = 0;
    setup(1, 31, 1, 1, 1);
    {Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Dateadv, Monthadv} = 7'b1000001;
    @(negedge Clk);
    Pulse = 1;
    @(negedge Clk);
    Pulse = 0;
    Reset = 1;
    #1 chk("rst_mid", obs(), 0);
    @(negedge Clk);
    Reset = 0;
    @(negedge Clk);
    chk("rst_noclamp", obs(), 0);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        mo = $urandom_range(1, 12);
        d = coin() ? dim_tb(mo) : $urandom_range(1, dim_tb(mo));
        h = coin() ? 23 : $urandom_range(0, 23);
        m = coin() ? 59 : $urandom_range(0, 59);
        s = 59;
      end
      ts = $urandom_range(0, 3) == 0;
      {as, ma, ha, dya, dta, moa} = 6'($urandom);
      aon = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 3) == 0) begin
        am = (m + 1) % 60;
        ah = (m == 59) ? (h + 1) % 24 : h;
      end
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/time_adv_sched.md
# time_adv_sched

Sequencing controller for the alarm-clock/calendar datapath. Once per `Pulse` tick it decides which counters advance: seconds, minutes, hours, day-of-week, date, month, alarm minutes and alarm hours. It applies the normal carry chain, the month-length-aware date rollover, manual-advance steering under `Timeset`/`Alarmset`, and post-set date clamping. It sits between the top-level buttons and the dumb modulo counters, and owns the `Buzz` alarm state machine.

## Interface
Parameters:
- `DAYS_FEB`, default 28: length of February; no leap-year support.

Ports:
- `Clk`  in  1: system clock; all state changes on its rising edge.
- `Reset`  in  1: asynchronous, active-high.
- `Pulse`  in  1: one-`Clk` strobe per second; consecutive strobes at least 3 `Clk` apart.
- `Timeset`, `Alarmset`  in  1: set-mode levels.
- `Minadv`, `Hrsadv`, `Dayadv`, `Dateadv`, `Monthadv`  in  1: advance-button levels.
- `Alarmon`  in  1: alarm enable.
- `Sec`  in  6: current seconds, 0–59.
- `Min`  in  6: current minutes, 0–59.
- `Hrs`  in  5: current hours, 0–23.
- `Date`  in  5: current date, 1–31.
- `Month`  in  4: current month, 1–12.
- `AMin`  in  6: alarm minutes.
- `AHrs`  in  5: alarm hours.
- `SecInc`, `MinInc`, `HrsInc`, `DayInc`, `DateInc`, `MonthInc`  out  1: one-cycle increment strobes. Each counter wraps itself (month wraps 12→1).
- `DateLd`  out  1: date reload strobe.
- `DateLdVal`  out  5: value to load when `DateLd` is high.
- `AMinInc`, `AHrsInc`  out  1: alarm counter increment strobes.
- `Buzz`  out  1: alarm sound.

## Operation
- Mode is sampled on `Pulse`:
  - RUN when `Timeset=0` and `Alarmset=0`.
  - TSET when `Timeset=1`. `Timeset` has priority; `Alarmset` is ignored.
  - ASET when `Alarmset=1` and `Timeset=0`.
- RUN carry chain:
  - `SecInc` always.
  - `MinInc` if `Sec==59`.
  - `HrsInc` if additionally `Min==59`.
  - `DayInc` if additionally `Hrs==23`.
  - Date step if additionally `Hrs==23`: when `Date==dim(Month)`, assert `DateLd` with `DateLdVal=1`; otherwise assert `DateInc`.
  - `MonthInc` if the date reload fired.
- TSET:
  - No `SecInc`; seconds freeze.
  - Each held advance button produces its own strobe once per `Pulse`, with no carry: `Minadv`→`MinInc`, `Hrsadv`→`HrsInc`, `Dayadv`→`DayInc`, `Monthadv`→`MonthInc`.
  - `Dateadv` at `Date==dim(Month)` gives `DateLd` with value 1; otherwise `DateInc`.
  - Any number of buttons may be active on the same `Pulse`.
- ASET:
  - Time runs exactly as in RUN.
  - `Minadv`→`AMinInc`, `Hrsadv`→`AHrsInc`.
  - `Dayadv`, `Dateadv` and `Monthadv` are ignored.
- Clamp:
  - A flag `clamp_pend` sets whenever `MonthInc` is issued in TSET.
  - On the 2nd `Clk` after that strobe, once `Month` has settled: if `Date > dim(Month)`, assert `DateLd` with `DateLdVal=dim(Month)`.
  - The flag then clears.
  - If a `Pulse` lands on the clamp cycle, the clamp wins and that Pulse's date strobe is dropped.
- `dim`: Jan, Mar, May, Jul, Aug, Oct, Dec = 31; Apr, Jun, Sep, Nov = 30; Feb = `DAYS_FEB`. Out-of-range `Month` is treated as 31.
- Buzz FSM, states IDLE and RING:
  - IDLE→RING on a RUN `Pulse` with `Alarmon=1`, `Sec==59`, and (`Min`,`Hrs`) +1 minute equal to (`AMin`,`AHrs`). Buzz therefore starts as the minute rolls over to the alarm time.
  - RING→IDLE when `Alarmon=0`. This is checked every `Clk`.
  - Entering TSET or ASET does not silence the alarm.

## Timing
- All outputs are registered. Strobes go high exactly one `Clk` after the `Pulse` cycle and last exactly one `Clk`.
- Decisions use `Sec`/`Min`/… as sampled in the `Pulse` cycle. Counters update one `Clk` after the strobe, so inputs are stable again before the next `Pulse` (≥3-cycle spacing).
- Clamp `DateLd` appears 2 `Clk` after the `MonthInc` that triggered it.
- `Buzz` rises one `Clk` after the qualifying `Pulse` and falls one `Clk` after `Alarmon` goes low.
- Reset, asynchronous: every strobe is 0, `DateLdVal=0`, `Buzz=0`, FSM is IDLE, `clamp_pend=0`.
- Reset asserted mid-sequence drops any pending strobe or clamp; nothing is replayed after release.
- Mode or button edges between Pulses have no effect. Only the level at `Pulse` counts.

## Structure
- Package `clock_pkg`:
  - constants `SEC_MAX=59`, `MIN_MAX=59`, `HRS_MAX=23`, `MONTH_MAX=12`;
  - enum `mode_e {RUN, TSET, ASET}`;
  - enum `buzz_st_e {IDLE, RING}`;
  - function `dim(month, days_feb)`.
- One sub-module: `buzz_ctrl`, holding the alarm-match compare and the IDLE/RING FSM. `time_adv_sched` instantiates it.

## Test plan
- RUN at 12/31 23:59:59, `Pulse` → in one cycle `SecInc`, `MinInc`, `HrsInc`, `DayInc`, `MonthInc`, plus `DateLd=1` with `DateLdVal=1`; `DateInc=0`.
- RUN at 02/28 23:59:59 → `DateLd`, value 1, and `MonthInc`. The same test at 04/30 behaves identically; at 01/30 it gives `DateInc` only.
- TSET with `Monthadv` and `Dateadv` held for 11 Pulses from 01/01 → 11 `MonthInc` and 11 `DateInc`; `SecInc` never fires; no `MinInc`/`HrsInc` carries.
- TSET at 01/31, one `Monthadv` Pulse (month becomes 2) → `DateLd=1` with `DateLdVal=28` 2 `Clk` after `MonthInc`.
- ASET with `Hrsadv` held → `AHrsInc` per Pulse, `HrsInc=0`, `SecInc` still fires. With `Timeset` and `Alarmset` both high → `HrsInc` instead.
- Alarm at 06:30, `Alarmon=1`, time 06:29:59, `Pulse` → `Buzz=1` next `Clk` and holds across further Pulses. `Alarmon=0` → `Buzz=0` one `Clk` later. `Reset` while ringing → `Buzz=0` immediately.
